// File: rtl/nested_loop_counter_pkg.sv
// nested_loop_counter_pkg: shared types for the nested loop index generator
package nested_loop_counter_pkg;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/nested_loop_counter_stage.sv
// loop_counter_stage: one odometer level, wraps to 0 at its inclusive maximum
module loop_counter_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             carry_in,
   input  logic [WIDTH-1:0] max,
   output logic [WIDTH-1:0] count,
   output logic             carry_out
);
   logic [WIDTH-1:0] count_q, count_d;
   logic             hit;
   assign hit       = count_q == max;
   assign carry_out = carry_in & hit;
   assign count     = count_q;
   always_comb count_d = clear ? '0 : carry_in ? (hit ? '0 : count_q + 1'b1) : count_q;
   always_ff @(posedge clk)
      if (rst) count_q <= '0;
      else     count_q <= count_d;
endmodule

// File: rtl/nested_loop_counter.sv
// nested_loop_counter: NUM_LOOPS-level odometer delivering index tuples on a
// valid/ready stream, with single-pass and continuous sweep modes.
module nested_loop_counter
   import nested_loop_counter_pkg::*;
#(
   parameter int NUM_LOOPS = 3,
   parameter int WIDTH     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       continuous,
   input  logic                       abort,
   input  logic [NUM_LOOPS*WIDTH-1:0] max_in,
   output logic [NUM_LOOPS*WIDTH-1:0] count,
   output logic                       count_valid,
   input  logic                       count_ready,
   output logic [NUM_LOOPS-1:0]       wrap,
   output logic                       last,
   output logic                       busy
);
   state_e                     state_q, state_d;
   logic [NUM_LOOPS*WIDTH-1:0] max_q, max_d, cnt;
   logic                       cont_q, cont_d;
   logic                       run, load, accept, clear;
   logic [NUM_LOOPS:0]         carry;
   logic [NUM_LOOPS-1:0]       hit, all_hit;
   assign run      = state_q == RUN;
   assign load     = !run && start && !abort;
   assign accept   = run && count_ready;
   assign clear    = load || abort;
   assign carry[0] = accept;
   assign max_d    = load ? max_in : max_q;
   assign cont_d   = load ? continuous : cont_q;
   // carry[] only moves on accepted beats; all_hit gives the wrap view even while stalled
   for (genvar i = 0; i < NUM_LOOPS; i++) begin : g_level
      loop_counter_stage #(.WIDTH(WIDTH)) u_stage (
         .clk      (clk),
         .rst      (rst),
         .clear    (clear),
         .carry_in (carry[i]),
         .max      (max_q[i*WIDTH +: WIDTH]),
         .count    (cnt[i*WIDTH +: WIDTH]),
         .carry_out(carry[i+1])
      );
      assign hit[i]     = cnt[i*WIDTH +: WIDTH] == max_q[i*WIDTH +: WIDTH];
      assign all_hit[i] = &hit[i:0];
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         max_q   <= '0;
         cont_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         max_q   <= max_d;
         cont_q  <= cont_d;
      end
   // a completed single-pass sweep has already wrapped every level back to 0
   always_comb
      state_d = run ? ((abort || (carry[NUM_LOOPS] && !cont_q)) ? IDLE : RUN)
                    : (load ? RUN : IDLE);
   always_comb begin
      count_valid = run;
      busy        = run;
      count       = run ? cnt : '0;
      wrap        = run ? all_hit : '0;
      last        = run && all_hit[NUM_LOOPS-1];
   end
endmodule

// File: tb/tb_nested_loop_counter.sv
// tb_nested_loop_counter: directed checks of sweep order, handshake, modes and control
module tb_nested_loop_counter;
   logic        clk = 1'b0;
   logic        rst, start, continuous, abort, count_ready;
   logic [23:0] max_in, count;
   logic        count_valid, last, busy;
   logic [2:0]  wrap;
   int          n_cmp = 0;
   int          n_bad = 0;

   nested_loop_counter #(.NUM_LOOPS(3), .WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .continuous (continuous),
      .abort      (abort),
      .max_in     (max_in),
      .count      (count),
      .count_valid(count_valid),
      .count_ready(count_ready),
      .wrap       (wrap),
      .last       (last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // expected {valid, count, wrap, last} for beat k of a sweep, derived by division
   function automatic logic [28:0] exp_beat(input int k, input int m0, input int m1, input int m2);
      int c0, c1, c2, total;
      logic [2:0] w;
      total = (m0 + 1) * (m1 + 1) * (m2 + 1);
      k  = k % total;
      c0 = k % (m0 + 1);
      c1 = (k / (m0 + 1)) % (m1 + 1);
      c2 = k / ((m0 + 1) * (m1 + 1));
      w[0] = c0 == m0;
      w[1] = w[0] && c1 == m1;
      w[2] = w[1] && c2 == m2;
      return {1'b1, c2[7:0], c1[7:0], c0[7:0], w, k == total - 1};
   endfunction

   task automatic do_start(input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2, input logic c);
      start = 1'b1;
      max_in = {m2, m1, m0};
      continuous = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      max_in = 24'h030201;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({count_valid, busy, count, wrap, last} !== 29'd0) begin
         n_bad++;
         $display("FAIL reset: got %h want 0", {count_valid, busy, count, wrap, last});
      end
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({count_valid, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_idle: got %b want 00", {count_valid, busy});
      end
   endtask

   task automatic test_single_pass();
      logic [28:0] e;
      count_ready = 1'b1;
      do_start(3, 2, 1, 1'b0);
      for (int k = 0; k < 24; k++) begin
         e = exp_beat(k, 3, 2, 1);
         n_cmp++;
         if ({count_valid, count, wrap, last} !== e) begin
            n_bad++;
            $display("FAIL single_pass beat %0d: got %h want %h", k, {count_valid, count, wrap, last}, e);
         end
         @(negedge clk);
      end
      n_cmp++;
      if ({count_valid, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL single_pass_end: got %b want 00", {count_valid, busy});
      end
      do_start(3, 2, 1, 1'b0);
      n_cmp++;
      if ({count_valid, busy, count} !== {2'b11, 24'd0}) begin
         n_bad++;
         $display("FAIL back_to_back: got %h want %h", {count_valid, busy, count}, {2'b11, 24'd0});
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [28:0] e;
      logic [15:0] pat = 16'b1011_0010_0110_1001;
      int k = 0;
      do_start(3, 2, 1, 1'b0);
      for (int cyc = 0; cyc < 200 && k < 24; cyc++) begin
         e = exp_beat(k, 3, 2, 1);
         n_cmp++;
         if ({count_valid, count, wrap, last} !== e) begin
            n_bad++;
            $display("FAIL stall beat %0d cyc %0d: got %h want %h", k, cyc, {count_valid, count, wrap, last}, e);
         end
         count_ready = pat[cyc % 16];
         @(negedge clk);
         if (count_ready) k++;
      end
      count_ready = 1'b1;
      n_cmp++;
      if (k != 24 || count_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_end: got beats %0d valid %b want 24 0", k, count_valid);
      end
   endtask

   task automatic test_continuous();
      logic [28:0] e;
      do_start(1, 1, 1, 1'b1);
      for (int k = 0; k < 24; k++) begin
         e = exp_beat(k, 1, 1, 1);
         n_cmp++;
         if ({count_valid, count, wrap, last} !== e) begin
            n_bad++;
            $display("FAIL continuous beat %0d: got %h want %h", k, {count_valid, count, wrap, last}, e);
         end
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++;
      if ({count_valid, count} !== 25'd0) begin
         n_bad++;
         $display("FAIL continuous_abort: got %h want 0", {count_valid, count});
      end
   endtask

   task automatic test_boundaries();
      logic [28:0] e;
      do_start(0, 0, 0, 1'b0);
      n_cmp++;
      if ({count_valid, count, wrap, last} !== {1'b1, 24'd0, 3'b111, 1'b1}) begin
         n_bad++;
         $display("FAIL all_zero: got %h want %h", {count_valid, count, wrap, last}, {1'b1, 24'd0, 3'b111, 1'b1});
      end
      @(negedge clk);
      n_cmp++;
      if (count_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL all_zero_end: got %b want 0", count_valid);
      end
      do_start(255, 1, 0, 1'b0);
      for (int k = 0; k < 257; k++) begin
         if (k >= 255) begin
            e = exp_beat(k, 255, 1, 0);
            n_cmp++;
            if ({count_valid, count, wrap, last} !== e) begin
               n_bad++;
               $display("FAIL max255 beat %0d: got %h want %h", k, {count_valid, count, wrap, last}, e);
            end
         end
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic test_abort();
      logic [28:0] e;
      do_start(3, 2, 1, 1'b0);
      repeat (4) @(negedge clk);
      e = exp_beat(4, 3, 2, 1);
      n_cmp++;
      if ({count_valid, count, wrap, last} !== e) begin
         n_bad++;
         $display("FAIL abort_pre: got %h want %h", {count_valid, count, wrap, last}, e);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++;
      if ({count_valid, busy, count, wrap, last} !== 29'd0) begin
         n_bad++;
         $display("FAIL abort: got %h want 0", {count_valid, busy, count, wrap, last});
      end
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      n_cmp++;
      if ({count_valid, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL abort_start_idle: got %b want 00", {count_valid, busy});
      end
   endtask

   task automatic test_rst_mid();
      do_start(3, 2, 1, 1'b1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({count_valid, busy, count, wrap, last} !== 29'd0) begin
         n_bad++;
         $display("FAIL rst_mid: got %h want 0", {count_valid, busy, count, wrap, last});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ignore_start();
      logic [28:0] e;
      do_start(3, 2, 1, 1'b0);
      for (int k = 0; k < 24; k++) begin
         e = exp_beat(k, 3, 2, 1);
         n_cmp++;
         if ({count_valid, count, wrap, last} !== e) begin
            n_bad++;
            $display("FAIL ignore_start beat %0d: got %h want %h", k, {count_valid, count, wrap, last}, e);
         end
         if (k == 2) begin
            start = 1'b1;
            max_in = 24'h010101;
            continuous = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
      end
      n_cmp++;
      if ({count_valid, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL ignore_start_end: got %b want 00", {count_valid, busy});
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      continuous = 1'b0;
      abort = 1'b0;
      count_ready = 1'b1;
      max_in = '0;
      @(negedge clk);
      test_reset();
      test_single_pass();
      test_backpressure();
      test_continuous();
      test_boundaries();
      test_abort();
      test_rst_mid();
      test_ignore_start();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/nested_loop_counter.md
# nested_loop_counter

Multi-level odometer counter that generates the index tuple for NUM_LOOPS nested loops, each level wrapping at its own run-time maximum. Level 0 is innermost and advances on every accepted beat; level i advances only when all inner levels wrap together. Indices are delivered on a valid/ready stream, so downstream address generators and datapath sequencers can stall the sweep. A start/abort control FSM supports single-pass and continuous modes.

## Interface
- NUM_LOOPS, 3, number of nested levels (>= 1)
- WIDTH, 8, bit width of each level's index and maximum
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; latches max_in and continuous, begins sweep (IDLE only)
- continuous  in  1  sampled with start; 1 = restart at all-zero after last beat
- abort  in  1  synchronous stop; return to IDLE
- max_in  in  NUM_LOOPS*WIDTH  per-level inclusive maximum, level i at bits [i*WIDTH +: WIDTH]
- count  out  NUM_LOOPS*WIDTH  current index tuple, same packing
- count_valid  out  1  count is a valid beat
- count_ready  in  1  downstream accepts beat when valid & ready
- wrap  out  NUM_LOOPS  wrap[i] = carry out of level i for the current beat
- last  out  1  current beat is the final tuple of the sweep (= wrap[NUM_LOOPS-1])
- busy  out  1  FSM in RUN

## Operation
- States: IDLE, RUN.
- IDLE: count = 0, count_valid = 0, busy = 0. start -> RUN; max_in copied into max_q, continuous into cont_q, all levels cleared to 0.
- RUN: count_valid = 1, busy = 1. Beat accepted when count_valid & count_ready.
- On accepted beat: level 0 always receives carry-in. Level i with carry-in: if count[i] == max_q[i] then 0, else +1. Carry-out wrap[i] = carry-in & (count[i] == max_q[i]). Levels without carry-in hold.
- wrap and last are combinational from count and max_q; valid only while count_valid = 1, forced 0 in IDLE.
- Accepted beat with last = 1: cont_q = 1 -> all levels 0, stay RUN; cont_q = 0 -> IDLE.
- Arithmetic: unsigned, equality compare only; max = 2^WIDTH-1 wraps to 0 with no overflow. max_q[i] = 0 -> level i fixed at 0, always wraps when carried into.
- Sweep length = product over i of (max_q[i]+1) beats.
- start in RUN ignored; max_in and continuous changes in RUN ignored (shadowed).
- abort in RUN -> IDLE next cycle, counts cleared; a beat accepted in the same cycle counts as consumed. abort in IDLE no effect. abort and start together in IDLE: abort wins, stay IDLE.
- rst: state IDLE, count 0, max_q 0, cont_q 0; all outputs 0. Overrides start/abort/handshake.

## Timing
- start at edge t -> count_valid = 1, count = 0 after edge t.
- One beat per cycle max; zero-bubble under continuous ready.
- Backpressure: while count_valid & !count_ready, count, wrap, last stable.
- Single-pass: count_valid drops the cycle after the last accepted beat; new start accepted the following cycle (IDLE for >= 1 cycle).
- Continuous: tuple after last is all-zero on the very next cycle, no gap.

## Structure
- Package nested_loop_counter_pkg: state enum (IDLE, RUN).
- Sub-module loop_counter_stage: one level; ports clk, rst, clear, carry_in, max, count, carry_out; instantiated NUM_LOOPS times via generate, carry chained level i -> i+1.
- Top: FSM, shadow registers, handshake, packing.

## Test plan
- NUM_LOOPS=3, WIDTH=8, max levels {0:3,1:2,2:1}, continuous=0, ready=1 -> 24 beats (0,0,0),(1,0,0)...(3,2,1); last only on beat 24; wrap[0] every 4th beat; valid 0 afterwards.
- Same config, ready random 50% -> identical 24-tuple sequence, count stable while stalled, no beats lost/duplicated.
- continuous=1, max {1,1,1} -> after (1,1,1) next cycle (0,0,0), valid stays 1 for 3 full sweeps.
- max all 0 -> single beat (0,0,0) with wrap=3'b111, last=1; max level 0 = 255 -> 255 wraps to 0, level 1 increments.
- abort at beat 5 with ready=1 -> IDLE next cycle, count 0; rst mid-sweep -> all outputs 0 next cycle.
- start pulsed and max_in changed during RUN -> ignored; sweep completes with original max values.
